// File: rtl/blink_core_sched.sv
// blink_core_sched: round-robin sequencer sharing one Blink_128_256 core
// between two requesters. A job is accepted on valid/ready, the core is
// pulsed through reset, C is captured after CORE_LAT cycles and returned
// on a valid/ready response port. Key register rewrites (K0/K1) are
// granted only while idle so the key never changes under a running job.
//
// Optional feature: define BLINK_SCHED_PERF_EN to add the perf_jobs and
// perf_busy counters. Without the macro those ports and counters are absent.
module blink_core_sched #(
    parameter int N        = 128,
    parameter int TW       = 256,
    parameter int CORE_LAT = 10,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_enc,
    input  logic [2*N-1:0]    req_p,
    input  logic [2*TW-1:0]   req_t,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_c,
    output logic              rsp_id,
    input  logic              key_req,
    output logic              key_gnt,
    output logic              core_rst,
    output logic              core_enc,
    output logic [N-1:0]      core_p,
    output logic [TW-1:0]     core_t,
    input  logic [N-1:0]      core_c,
    output logic              busy
`ifdef BLINK_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_jobs,
    output logic [31:0]       perf_busy
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEY  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;

    // Round-robin memory: index of the requester granted most recently.
    logic             last;
    // Counts RUN cycles since the core left reset.
    logic [CNT_W-1:0] cnt;

    logic             sel;
    logic [1:0]       grant;
    logic             accept;
    logic             run_done;
    logic             rsp_done;

    // The capture happens on the last of CORE_LAT RUN cycles.
    assign run_done = (state == RUN) && (cnt == CNT_W'(CORE_LAT - 1));
    assign rsp_done = (state == DONE) && rsp_ready;

    // Arbitration: key requests pre-empt jobs; with both requesters valid
    // the one not served last wins, otherwise the single valid one wins.
    always_comb begin
        sel   = 1'b0;
        grant = 2'b00;
        if ((state == IDLE) && !key_req && !rst) begin
            if (req_valid == 2'b11) begin
                sel = ~last;
            end else begin
                sel = req_valid[1];
            end
            if (req_valid[sel]) begin
                grant = 2'b01 << sel;
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the job/key sequencing.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (key_req) begin
                    state_next = KEY;
                end else if (accept) begin
                    state_next = LOAD;
                end
            end
            KEY: begin
                if (!key_req) begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if (run_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pointer and response id are updated only by an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            last   <= 1'b1;
            rsp_id <= 1'b0;
        end else if (accept) begin
            last   <= sel;
            rsp_id <= sel;
        end
    end

    // Core operands are latched on accept and held for the whole job.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_p   <= '0;
            core_t   <= '0;
            core_enc <= 1'b0;
        end else if (accept) begin
            core_p   <= sel ? req_p[2*N-1:N]   : req_p[N-1:0];
            core_t   <= sel ? req_t[2*TW-1:TW] : req_t[TW-1:0];
            core_enc <= req_enc[sel];
        end
    end

    // Latency counter: cleared while the core is in reset, counts in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == LOAD) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Result capture at the end of the core latency window.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_c <= '0;
        end else if (run_done) begin
            rsp_c <= core_c;
        end
    end

    // Outputs decoded from the registered state; core reset follows the
    // system reset and is also pulsed for the single LOAD cycle.
    assign rsp_valid = (state == DONE);
    assign key_gnt   = (state == KEY);
    assign busy      = (state != IDLE);
    assign core_rst  = rst || (state == LOAD);

`ifdef BLINK_SCHED_PERF_EN
    // Free-running wrap-around counters of completed jobs and busy cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_jobs <= '0;
            perf_busy <= '0;
        end else begin
            if (rsp_done) begin
                perf_jobs <= perf_jobs + 32'd1;
            end
            if (busy) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`else
    logic unused_done;
    assign unused_done = rsp_done;
`endif

endmodule

// File: tb/tb_blink_core_sched.sv
// Testbench for blink_core_sched: directed sequence with randomized
// operands, a stub core with a fixed latency, and a job-level reference.
module tb_blink_core_sched;

    localparam int N        = 128;
    localparam int TW       = 256;
    localparam int CORE_LAT = 10;
    localparam int CNT_W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_enc;
    logic [2*N-1:0]    req_p;
    logic [2*TW-1:0]   req_t;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_c;
    logic              rsp_id;
    logic              key_req;
    logic              key_gnt;
    logic              core_rst;
    logic              core_enc;
    logic [N-1:0]      core_p;
    logic [TW-1:0]     core_t;
    logic [N-1:0]      core_c;
    logic              busy;
`ifdef BLINK_SCHED_PERF_EN
    logic [31:0]       perf_jobs;
    logic [31:0]       perf_busy;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int jobs   = 0;

    logic [N-1:0]  rp [2];
    logic [TW-1:0] rt [2];
    logic          re [2];

    int            last_ref;
    int            gi;
    logic [N-1:0]  exp_p;
    logic [N-1:0]  exp_c;
    logic [TW-1:0] exp_t;
    logic          exp_enc;
    logic          exp_id;
    int            acc_cyc = 0;
    int            prev_acc = 0;
    logic [7:0]    ccyc = 8'd0;

    always #5 clk = ~clk;

    blink_core_sched #(
        .N(N), .TW(TW), .CORE_LAT(CORE_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc),
        .req_p(req_p), .req_t(req_t),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_id(rsp_id),
        .key_req(key_req), .key_gnt(key_gnt),
        .core_rst(core_rst), .core_enc(core_enc), .core_p(core_p), .core_t(core_t),
        .core_c(core_c), .busy(busy)
`ifdef BLINK_SCHED_PERF_EN
        , .perf_jobs(perf_jobs), .perf_busy(perf_busy)
`endif
    );

    // Stand-in cipher: any fixed mixing of P, T and enc serves the purpose.
    function automatic logic [N-1:0] blk(input logic [N-1:0] p, input logic [TW-1:0] t, input logic enc);
        if (enc) return (p ^ t[N-1:0]) + t[TW-1:N];
        else     return (p + ~t[TW-1:N]) ^ {t[63:0], t[127:64]};
    endfunction

    // Stub core: C is correct only from the CORE_LAT-th cycle after reset release.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_rst) ccyc <= 8'd1;
        else if (ccyc != 8'hFF) ccyc <= ccyc + 8'd1;
    end
    assign core_c = (ccyc >= 8'(CORE_LAT)) ? blk(core_p, core_t, core_enc)
                                           : ~blk(core_p, core_t, core_enc);

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive();
        req_p   = {rp[1], rp[0]};
        req_t   = {rt[1], rt[0]};
        req_enc = {re[1], re[0]};
    endtask

    task automatic scramble();
        for (int i = 0; i < 2; i++) begin
            rp[i] = r128();
            rt[i] = {r128(), r128()};
            re[i] = 1'($urandom_range(0, 1));
        end
        drive();
    endtask

    // Present a request in an IDLE cycle, check the grant, then the LOAD cycle.
    task automatic start_job(input logic [1:0] vmask);
        req_valid = vmask;
        drive();
        #1;
        if (vmask == 2'b11) gi = (last_ref == 0) ? 1 : 0;
        else                gi = vmask[0] ? 0 : 1;
        chk("req_ready_grant", req_ready, 2'b01 << gi);
        chk("key_gnt_idle", key_gnt, 1'b0);
        exp_p    = rp[gi];
        exp_t    = rt[gi];
        exp_enc  = re[gi];
        exp_c    = blk(exp_p, exp_t, exp_enc);
        exp_id   = 1'(gi);
        last_ref = gi;
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        @(negedge clk);
        scramble();
        #1;
        chk("load_core_rst", core_rst, 1'b1);
        chk("load_busy", busy, 1'b1);
        chk("load_req_ready", req_ready, 2'b00);
        chk("load_core_p", core_p, exp_p);
        chk("load_core_t", core_t, exp_t);
        chk("load_core_enc", core_enc, exp_enc);
    endtask

    task automatic run_cycles(input int n, input bit key_mid);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_mid && i == 2) key_req = 1'b1;
            #1;
            chk("run_rsp_valid", rsp_valid, 1'b0);
            chk("run_core_rst", core_rst, 1'b0);
            chk("run_req_ready", req_ready, 2'b00);
            chk("run_key_gnt", key_gnt, 1'b0);
            chk("run_core_p", core_p, exp_p);
            chk("run_core_t", core_t, exp_t);
        end
    endtask

    task automatic finish_job(input int hold);
        @(negedge clk);
        #1;
        chk("done_rsp_valid", rsp_valid, 1'b1);
        chk("done_rsp_c", rsp_c, exp_c);
        chk("done_rsp_id", rsp_id, exp_id);
        chk("done_key_gnt", key_gnt, 1'b0);
        chk("done_core_enc", core_enc, exp_enc);
        for (int h = 0; h < hold; h++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 1'b0;
            #1;
            chk("bp_req_ready", req_ready, 2'b00);
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_c", rsp_c, exp_c);
            chk("bp_rsp_id", rsp_id, exp_id);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        jobs++;
        #1;
        chk("release_busy", busy, 1'b0);
        chk("release_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        key_req   = 1'b0;
        scramble();
        last_ref  = 1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_c", rsp_c, '0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_key_gnt", key_gnt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_core_p", core_p, '0);
        chk("rst_core_t", core_t, '0);
        chk("rst_core_enc", core_enc, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_core_rst", core_rst, 1'b0);

        // Single job with zero operands from requester 0
        rp[0] = '0; rt[0] = '0; re[0] = 1'b1;
        start_job(2'b01);
        run_cycles(CORE_LAT, 1'b0);
        finish_job(0);

        // Contention: both requesters valid, grants alternate 13 cycles apart
        for (int k = 0; k < 4; k++) begin
            scramble();
            start_job(2'b11);
            if (k > 0) chk("rr_spacing", acc_cyc - prev_acc, CORE_LAT + 3);
            run_cycles(CORE_LAT, 1'b0);
            finish_job(0);
        end

        // Single job from requester 1
        scramble();
        start_job(2'b10);
        run_cycles(CORE_LAT, 1'b0);
        finish_job(0);

        // Backpressure for 20 cycles
        scramble();
        start_job(2'b01);
        run_cycles(CORE_LAT, 1'b0);
        finish_job(20);

        // Key request raised mid-RUN waits for the job, then beats a pending job
        scramble();
        start_job(2'b11);
        run_cycles(CORE_LAT, 1'b1);
        finish_job(0);
        req_valid = 2'b01;
        #1;
        chk("key_idle_req_ready", req_ready, 2'b00);
        chk("key_idle_gnt", key_gnt, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("key_gnt_held", key_gnt, 1'b1);
            chk("key_busy", busy, 1'b1);
            chk("key_req_ready", req_ready, 2'b00);
        end
        key_req = 1'b0;
        #1;
        chk("key_gnt_drop_cycle", key_gnt, 1'b1);
        @(negedge clk);
        scramble();
        start_job(2'b01);
        run_cycles(CORE_LAT, 1'b0);
        finish_job(0);

        // Reset at cycle t+5 of a job
        scramble();
        start_job(2'b11);
        run_cycles(3, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("midrst_core_rst_now", core_rst, 1'b1);
        @(negedge clk);
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_core_rst", core_rst, 1'b1);
        chk("midrst_rsp_c", rsp_c, '0);
        chk("midrst_rsp_id", rsp_id, 1'b0);
        chk("midrst_core_p", core_p, '0);
        rst      = 1'b0;
        last_ref = 1;
        jobs     = 0;
        @(negedge clk);
        #1;
        chk("midrst_release_core_rst", core_rst, 1'b0);
        chk("midrst_release_busy", busy, 1'b0);
        scramble();
        start_job(2'b11);
        run_cycles(CORE_LAT, 1'b0);
        finish_job(0);

        // Randomized job mix with random backpressure and withdrawals
        for (int k = 0; k < 8; k++) begin
            scramble();
            start_job(2'($urandom_range(1, 3)));
            run_cycles(CORE_LAT, 1'b0);
            finish_job($urandom_range(0, 3));
        end

`ifdef BLINK_SCHED_PERF_EN
        chk("perf_jobs", perf_jobs, 32'(jobs));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
